// File: rtl/trap_controller.sv
// Machine-mode trap entry / mret sequencer: flushes, stalls, writes mepc and
// mcause over the shared CSR write port, then issues one PC redirect.
module trap_controller #(
  parameter logic [11:0] MEPC_ADDR     = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR   = 12'h342,
  parameter logic [31:0] CAUSE_ILLEGAL = 32'd2,
  parameter logic [31:0] CAUSE_ECALL   = 32'd11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trap_valid,
  input  logic        illegal_ir,
  input  logic        is_ecall,
  input  logic        is_mret,
  input  logic [31:0] trap_pc,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic        ex_wr_csr_n,
  input  logic [11:0] ex_csr_addr,
  input  logic [31:0] ex_csr_wdata,
  output logic        csr_wr_n,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  output logic        flush,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WR_EPC, WR_CAUSE, REDIRECT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, cause_q;
  logic        ret_q;
  logic        is_trap, accept;

  assign is_trap = illegal_ir | is_ecall;
  assign accept  = (state_q == IDLE) && trap_valid && (is_trap || is_mret);
  assign busy    = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ret_q <= ~is_trap;
        if (is_trap) begin
          pc_q    <= trap_pc;
          cause_q <= illegal_ir ? CAUSE_ILLEGAL : CAUSE_ECALL;
        end
      end
    end
  end

  // Outputs are gated by rst_n so reset values hold even with live ex_* inputs.
  always_comb begin
    state_d     = state_q;
    csr_wr_n    = 1'b1;
    csr_addr    = '0;
    csr_wdata   = '0;
    flush       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          csr_addr  = ex_csr_addr;
          csr_wdata = ex_csr_wdata;
          if (accept) begin
            // The coincident EX write belongs to a flushed instruction.
            flush   = 1'b1;
            state_d = is_trap ? WR_EPC : REDIRECT;
          end else begin
            csr_wr_n = ex_wr_csr_n;
          end
        end
        WR_EPC: begin
          csr_wr_n  = 1'b0;
          csr_addr  = MEPC_ADDR;
          csr_wdata = pc_q;
          flush     = 1'b1;
          stall     = 1'b1;
          state_d   = WR_CAUSE;
        end
        WR_CAUSE: begin
          csr_wr_n  = 1'b0;
          csr_addr  = MCAUSE_ADDR;
          csr_wdata = cause_q;
          flush     = 1'b1;
          stall     = 1'b1;
          state_d   = REDIRECT;
        end
        REDIRECT: begin
          flush       = 1'b1;
          stall       = 1'b1;
          redirect    = 1'b1;
          redirect_pc = ret_q ? {mepc[31:2], 2'b00} : {mtvec[31:2], 2'b00};
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
